p405s_utlb_bank_clock_ctl: RTL and testbench

Banked clock-enable controller for the UTLB array, generalised to `NUM_BANKS` independently gated banks. It generates per-bank C1 and array-L1 clock enables. It keeps each bank's clocks on for a programmable hold window after its last access, then lets the bank sleep. A stall signal is raised while a sleeping bank wakes. The block sits between the UTLB control logic (lookup/read/write requests) and the per-bank array clock splitters, and keeps the LSSD test overrides (`TestM3`, `TestComp`).

---
 rtl/p405s_utlb_clk_pkg.sv | 35 +++
 rtl/p405s_utlb_bank_clock_fsm.sv | 102 ++++++++++
 rtl/p405s_utlb_bank_clock_ctl.sv | 136 +++++++++++++
 tb/tb_p405s_utlb_bank_clock_ctl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p405s_utlb_clk_pkg.sv
// ---------------------------------------------------------------------------
// p405s_utlb_clk_pkg
//
// Shared definitions for the banked UTLB clock-enable controller:
//   - bank_state_t : per-bank clock state (SLEEP, WAKE, ACTIVE, HOLD)
//   - default parameter values used by the top level and the bank FSM
//   - small decode helpers on the bank state
// ---------------------------------------------------------------------------
package p405s_utlb_clk_pkg;

    // Encoding is fixed so that SLEEP is all-zeros: "bank awake" is then a
    // plain OR of the two state bits.
    typedef enum logic [1:0] {
        BANK_SLEEP  = 2'b00,
        BANK_WAKE   = 2'b01,
        BANK_ACTIVE = 2'b10,
        BANK_HOLD   = 2'b11
    } bank_state_t;

    localparam int DEFAULT_NUM_BANKS   = 4;
    localparam int DEFAULT_HOLD_CYCLES = 2;
    localparam int DEFAULT_HOLD_W      = 4;
    localparam int DEFAULT_CNT_W       = 16;

    // Bank may fire its array clock on a request this cycle.
    function automatic logic state_is_armed(input bank_state_t s);
        return (s == BANK_ACTIVE) || (s == BANK_HOLD);
    endfunction

    // Bank cannot serve a request yet; the requester has to stall.
    function automatic logic state_is_cold(input bank_state_t s);
        return (s == BANK_SLEEP) || (s == BANK_WAKE);
    endfunction

endpackage

// File: rtl/p405s_utlb_bank_clock_fsm.sv
// ---------------------------------------------------------------------------
// p405s_utlb_bank_clock_fsm
//
// Clock state machine for one UTLB array bank plus its hold-window counter.
// A request wakes a sleeping bank (one WAKE cycle, then ACTIVE). Once the
// requests stop, the bank lingers in HOLD for HOLD_CYCLES cycles before it
// returns to SLEEP, unless the hold is disabled.
//
// Ports:
//   clk        in   clock
//   reset_n    in   synchronous active-low reset
//   req        in   this bank is targeted by a request this cycle
//   hold_dis   in   skip the hold window (ACTIVE goes straight to SLEEP)
//   state      out  current bank state (registered)
//   wake_start out  bank leaves SLEEP for WAKE at the coming edge
// ---------------------------------------------------------------------------
module p405s_utlb_bank_clock_fsm
    import p405s_utlb_clk_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int HOLD_W      = DEFAULT_HOLD_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        hold_dis,
    output bank_state_t state,
    output logic        wake_start
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);

    bank_state_t       state_q;
    bank_state_t       state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;

    // State and hold counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= BANK_SLEEP;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic. WAKE always advances to ACTIVE, even if the request
    // went away during the wake cycle. A request seen in HOLD wins over an
    // expiring count, so a late re-request never loses the bank.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        wake_start = 1'b0;

        unique case (state_q)
            BANK_SLEEP: begin
                if (req) begin
                    state_d    = BANK_WAKE;
                    wake_start = 1'b1;
                end
            end

            BANK_WAKE: begin
                state_d = BANK_ACTIVE;
            end

            BANK_ACTIVE: begin
                if (!req) begin
                    if ((HOLD_CYCLES == 0) || hold_dis) begin
                        state_d = BANK_SLEEP;
                    end else begin
                        state_d    = BANK_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
            end

            BANK_HOLD: begin
                if (req) begin
                    state_d    = BANK_ACTIVE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = BANK_SLEEP;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_LAST;
                end
            end

            default: begin
                state_d    = BANK_SLEEP;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/p405s_utlb_bank_clock_ctl.sv
// ---------------------------------------------------------------------------
// p405s_utlb_bank_clock_ctl
//
// Banked clock-enable controller for the UTLB array. Each of NUM_BANKS banks
// has its own clock FSM; this level decodes requests to banks, qualifies the
// C1 and array-L1 clock enables, raises a stall while a targeted bank is
// waking, and counts wake events.
//
// Ports:
//   CB                    in   clock
//   Reset_N               in   synchronous active-low reset
//   C_Clock               in   C-phase qualifier for EN_C1
//   LSSD_ArrayCClk_buf    in   array C-clock qualifier for EN_ARRAYL1*
//   TestM3                in   scan mode, masks EN_ARRAYL1
//   TestComp              in   test compare, forces C1 enable on all banks
//   lookupEn              in   CAM lookup, targets every bank
//   rdEn, wrEn            in   read / write, target the banks in bankSel
//   bankSel               in   per-bank target mask for rd/wr
//   holdDis               in   disable the hold window
//   EN_C1                 out  per-bank C1 clock enable
//   EN_ARRAYL1            out  per-bank array enable after the TestM3 mask
//   EN_ARRAYL1_preTestM3  out  per-bank array enable before the TestM3 mask
//   bankActive            out  bank is not sleeping (from the state flops)
//   wakeStall             out  a targeted bank is still waking; hold request
//   wakeCnt               out  saturating count of SLEEP->WAKE transitions
// ---------------------------------------------------------------------------
module p405s_utlb_bank_clock_ctl
    import p405s_utlb_clk_pkg::*;
#(
    parameter int NUM_BANKS   = DEFAULT_NUM_BANKS,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int HOLD_W      = DEFAULT_HOLD_W,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic                 CB,
    input  logic                 Reset_N,
    input  logic                 C_Clock,
    input  logic                 LSSD_ArrayCClk_buf,
    input  logic                 TestM3,
    input  logic                 TestComp,
    input  logic                 lookupEn,
    input  logic                 rdEn,
    input  logic                 wrEn,
    input  logic [NUM_BANKS-1:0] bankSel,
    input  logic                 holdDis,
    output logic [NUM_BANKS-1:0] EN_C1,
    output logic [NUM_BANKS-1:0] EN_ARRAYL1,
    output logic [NUM_BANKS-1:0] EN_ARRAYL1_preTestM3,
    output logic [NUM_BANKS-1:0] bankActive,
    output logic                 wakeStall,
    output logic [CNT_W-1:0]     wakeCnt
);

    // Width of the per-cycle wake count (0..NUM_BANKS) and of the unsaturated
    // sum, wide enough that the addition itself can never wrap.
    localparam int NUM_W = $clog2(NUM_BANKS + 1);
    localparam int SUM_W = CNT_W + NUM_W;

    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [NUM_BANKS-1:0] bank_req;
    logic [NUM_BANKS-1:0] armed;
    logic [NUM_BANKS-1:0] awake;
    logic [NUM_BANKS-1:0] cold;
    logic [NUM_BANKS-1:0] wake_start;
    bank_state_t          bank_state [NUM_BANKS];

    logic [NUM_W-1:0]     wake_num;
    logic [SUM_W-1:0]     wake_sum;
    logic [CNT_W-1:0]     wake_cnt_q;
    logic [CNT_W-1:0]     wake_cnt_d;

    // A lookup probes the whole CAM; reads and writes only touch the
    // selected banks. Read and write may target overlapping banks.
    assign bank_req = {NUM_BANKS{lookupEn}}
                    | ({NUM_BANKS{rdEn | wrEn}} & bankSel);

    // One independent clock FSM per bank.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        p405s_utlb_bank_clock_fsm #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .HOLD_W      (HOLD_W)
        ) u_fsm (
            .clk        (CB),
            .reset_n    (Reset_N),
            .req        (bank_req[b]),
            .hold_dis   (holdDis),
            .state      (bank_state[b]),
            .wake_start (wake_start[b])
        );

        assign armed[b] = state_is_armed(bank_state[b]);
        assign cold[b]  = state_is_cold(bank_state[b]);
        assign awake[b] = (bank_state[b] != BANK_SLEEP);
    end

    // Clock enable qualification. The test overrides sit purely on the
    // output path so that scan/compare modes never disturb the FSMs.
    assign EN_ARRAYL1_preTestM3 = bank_req & armed & {NUM_BANKS{LSSD_ArrayCClk_buf}};
    assign EN_ARRAYL1           = EN_ARRAYL1_preTestM3 & ~{NUM_BANKS{TestM3}};
    assign EN_C1                = {NUM_BANKS{C_Clock}} & (awake | {NUM_BANKS{TestComp}});

    // bankActive is a decode of the state flops only, so it is glitch-free.
    assign bankActive = awake;

    // Stall while any targeted bank is sleeping or in its wake cycle.
    assign wakeStall = |(bank_req & cold);

    // Several banks can wake on the same edge (e.g. a lookup from all-sleep),
    // so the counter adds the number of banks entering WAKE and clamps at
    // all-ones instead of wrapping.
    always_comb begin
        wake_num = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            wake_num = wake_num + NUM_W'(wake_start[b]);
        end
        wake_sum = SUM_W'(wake_cnt_q) + SUM_W'(wake_num);
        if (wake_sum > CNT_MAX) begin
            wake_cnt_d = {CNT_W{1'b1}};
        end else begin
            wake_cnt_d = wake_sum[CNT_W-1:0];
        end
    end

    // Wake event counter register.
    always_ff @(posedge CB) begin
        if (!Reset_N) begin
            wake_cnt_q <= '0;
        end else begin
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign wakeCnt = wake_cnt_q;

endmodule

// File: tb/tb_p405s_utlb_bank_clock_ctl.sv
// ---------------------------------------------------------------------------
// tb_p405s_utlb_bank_clock_ctl
//
// Bench for the banked UTLB clock controller. Two instances share every
// input: one with the default 16-bit wake counter and one with a 3-bit
// counter so saturation is reached quickly. A timestamp-based model tracks
// for each bank whether it sleeps, when it started waking and the edge at
// which its hold window runs out; a compare process checks every output of
// both instances against it each cycle. A directed prologue pins the model
// with literal expectations, followed by randomized traffic and resets.
// ---------------------------------------------------------------------------
module tb_p405s_utlb_bank_clock_ctl;

    localparam int NB      = 4;
    localparam int HOLD    = 2;
    localparam int CNT_W   = 16;
    localparam int SAT_W   = 3;
    localparam int RAND_N  = 3000;

    logic          CB = 1'b0;
    logic          Reset_N = 1'b0;
    logic          C_Clock = 1'b1;
    logic          LSSD_ArrayCClk_buf = 1'b1;
    logic          TestM3 = 1'b0;
    logic          TestComp = 1'b0;
    logic          lookupEn = 1'b0;
    logic          rdEn = 1'b0;
    logic          wrEn = 1'b0;
    logic [NB-1:0] bankSel = '0;
    logic          holdDis = 1'b0;

    logic [NB-1:0]    en_c1, en_l1, en_pre, bank_active;
    logic             wake_stall;
    logic [CNT_W-1:0] wake_cnt;

    logic [NB-1:0]    s_en_c1, s_en_l1, s_en_pre, s_bank_active;
    logic             s_wake_stall;
    logic [SAT_W-1:0] s_wake_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 CB = ~CB;

    p405s_utlb_bank_clock_ctl #(
        .NUM_BANKS(NB), .HOLD_CYCLES(HOLD), .HOLD_W(4), .CNT_W(CNT_W)
    ) dut (
        .CB(CB), .Reset_N(Reset_N), .C_Clock(C_Clock),
        .LSSD_ArrayCClk_buf(LSSD_ArrayCClk_buf), .TestM3(TestM3),
        .TestComp(TestComp), .lookupEn(lookupEn), .rdEn(rdEn), .wrEn(wrEn),
        .bankSel(bankSel), .holdDis(holdDis),
        .EN_C1(en_c1), .EN_ARRAYL1(en_l1), .EN_ARRAYL1_preTestM3(en_pre),
        .bankActive(bank_active), .wakeStall(wake_stall), .wakeCnt(wake_cnt)
    );

    p405s_utlb_bank_clock_ctl #(
        .NUM_BANKS(NB), .HOLD_CYCLES(HOLD), .HOLD_W(4), .CNT_W(SAT_W)
    ) dut_sat (
        .CB(CB), .Reset_N(Reset_N), .C_Clock(C_Clock),
        .LSSD_ArrayCClk_buf(LSSD_ArrayCClk_buf), .TestM3(TestM3),
        .TestComp(TestComp), .lookupEn(lookupEn), .rdEn(rdEn), .wrEn(wrEn),
        .bankSel(bankSel), .holdDis(holdDis),
        .EN_C1(s_en_c1), .EN_ARRAYL1(s_en_l1), .EN_ARRAYL1_preTestM3(s_en_pre),
        .bankActive(s_bank_active), .wakeStall(s_wake_stall), .wakeCnt(s_wake_cnt)
    );

    // Compares one observed value with its expectation and tallies it.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and returns at
    // the following falling edge, where outputs are sampled.
    task automatic applyStimulus(input logic rst_n, input logic cc, input logic lssd,
                                 input logic lk, input logic rd, input logic wr,
                                 input logic [NB-1:0] sel, input logic hd,
                                 input logic tm3, input logic tc);
        @(posedge CB);
        #1;
        Reset_N            = rst_n;
        C_Clock            = cc;
        LSSD_ArrayCClk_buf = lssd;
        lookupEn           = lk;
        rdEn               = rd;
        wrEn               = wr;
        bankSel            = sel;
        holdDis            = hd;
        TestM3             = tm3;
        TestComp           = tc;
        @(negedge CB);
    endtask

    // ---------------- behavioural model ----------------
    // edge_n numbers rising edges; "cycle e" is the time after edge e.
    // A bank is waking during the cycle right after the edge where it left
    // sleep; afterwards it is armed. m_sleep_at < 0 means the bank is being
    // used (no hold window running); otherwise it is the edge at which the
    // bank falls asleep if nobody asks for it again.
    bit m_asleep   [NB];
    int m_wake_e   [NB];
    int m_sleep_at [NB];
    int m_count     = 0;
    int edge_n      = 0;
    bit model_valid = 1'b0;

    function automatic bit reqOf(input int b);
        return lookupEn | ((rdEn | wrEn) & bankSel[b]);
    endfunction

    always @(posedge CB) begin : model_update
        int e;
        int wakes;
        bit r;
        e     = edge_n + 1;
        wakes = 0;
        edge_n <= e;
        if (!Reset_N) begin
            for (int b = 0; b < NB; b++) begin
                m_asleep[b]   <= 1'b1;
                m_wake_e[b]   <= -10;
                m_sleep_at[b] <= -1;
            end
            m_count     <= 0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            for (int b = 0; b < NB; b++) begin
                r = reqOf(b);
                if (m_asleep[b]) begin
                    if (r) begin
                        m_asleep[b] <= 1'b0;
                        m_wake_e[b] <= e;
                        wakes++;
                    end
                end else if (m_wake_e[b] == edge_n || r) begin
                    m_sleep_at[b] <= -1;
                end else if (m_sleep_at[b] < 0) begin
                    if (holdDis || HOLD == 0) m_asleep[b] <= 1'b1;
                    else                      m_sleep_at[b] <= e + HOLD;
                end else if (m_sleep_at[b] == e) begin
                    m_asleep[b]   <= 1'b1;
                    m_sleep_at[b] <= -1;
                end
            end
            m_count <= m_count + wakes;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge CB) begin : compare
        logic [NB-1:0] x_c1, x_pre, x_l1, x_act;
        logic          x_stall;
        int            x_cnt, x_sat;
        bit            r, waking;
        if (model_valid) begin
            x_c1 = '0; x_pre = '0; x_act = '0; x_stall = 1'b0;
            for (int b = 0; b < NB; b++) begin
                r      = reqOf(b);
                waking = !m_asleep[b] && (m_wake_e[b] == edge_n);
                x_c1[b]  = C_Clock & (!m_asleep[b] | TestComp);
                x_pre[b] = r & !m_asleep[b] & !waking & LSSD_ArrayCClk_buf;
                x_act[b] = !m_asleep[b];
                if (r && (m_asleep[b] || waking)) x_stall = 1'b1;
            end
            x_l1  = x_pre & {NB{~TestM3}};
            x_cnt = (m_count > 65535) ? 65535 : m_count;
            x_sat = (m_count > 7) ? 7 : m_count;
            checkOutput("EN_C1",        32'(en_c1),         32'(x_c1));
            checkOutput("EN_ARRAYL1",   32'(en_l1),         32'(x_l1));
            checkOutput("EN_PRE",       32'(en_pre),        32'(x_pre));
            checkOutput("bankActive",   32'(bank_active),   32'(x_act));
            checkOutput("wakeStall",    32'(wake_stall),    32'(x_stall));
            checkOutput("wakeCnt",      32'(wake_cnt),      32'(x_cnt));
            checkOutput("sat.EN_C1",    32'(s_en_c1),       32'(x_c1));
            checkOutput("sat.EN_L1",    32'(s_en_l1),       32'(x_l1));
            checkOutput("sat.EN_PRE",   32'(s_en_pre),      32'(x_pre));
            checkOutput("sat.active",   32'(s_bank_active), 32'(x_act));
            checkOutput("sat.stall",    32'(s_wake_stall),  32'(x_stall));
            checkOutput("sat.wakeCnt",  32'(s_wake_cnt),    32'(x_sat));
        end
    end

    // ---------------- directed prologue + random traffic ----------------
    initial begin
        // Reset with a lookup pending and TestComp forcing C1 on.
        applyStimulus(0, 1, 1, 1, 0, 0, 4'b0000, 0, 0, 1);
        checkOutput("lit.rst.EN_C1",  32'(en_c1),      32'hF);
        checkOutput("lit.rst.EN_L1",  32'(en_l1),      32'h0);
        checkOutput("lit.rst.stall",  32'(wake_stall), 32'h1);
        checkOutput("lit.rst.cnt",    32'(wake_cnt),   32'h0);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);

        // Cold read of bank 1: two stall cycles, array enable on the third.
        applyStimulus(1, 1, 1, 0, 1, 0, 4'b0010, 0, 0, 0);
        checkOutput("lit.cold.stall0", 32'(wake_stall), 32'h1);
        checkOutput("lit.cold.c1_0",   32'(en_c1),      32'h0);
        applyStimulus(1, 1, 1, 0, 1, 0, 4'b0010, 0, 0, 0);
        checkOutput("lit.cold.stall1", 32'(wake_stall), 32'h1);
        checkOutput("lit.cold.c1_1",   32'(en_c1),      32'h2);
        applyStimulus(1, 1, 1, 0, 1, 0, 4'b0010, 0, 0, 0);
        checkOutput("lit.cold.stall2", 32'(wake_stall), 32'h0);
        checkOutput("lit.cold.l1",     32'(en_l1),      32'h2);
        checkOutput("lit.cold.cnt",    32'(wake_cnt),   32'h1);

        // Requests stop: ACTIVE one more cycle, two HOLD cycles, then SLEEP.
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        checkOutput("lit.hold.a0", 32'(bank_active), 32'h2);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        checkOutput("lit.hold.a1", 32'(bank_active), 32'h2);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        checkOutput("lit.hold.a2", 32'(bank_active), 32'h2);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        checkOutput("lit.hold.a3", 32'(bank_active), 32'h0);

        // Wake bank 1 again, then re-request on the last HOLD cycle.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 1, 0, 4'b0010, 0, 0, 0);
        checkOutput("lit.rewake.cnt", 32'(wake_cnt), 32'h2);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 0, 4'b0010, 0, 0, 0);
        checkOutput("lit.rereq.stall", 32'(wake_stall), 32'h0);
        checkOutput("lit.rereq.l1",    32'(en_l1),      32'h2);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
        checkOutput("lit.rereq.act",   32'(bank_active), 32'h2);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
        checkOutput("lit.holddis.a",   32'(bank_active), 32'h0);

        // Lookup from all-sleep wakes all four banks together.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 1, 0, 0, 4'b0000, 1, 0, 0);
        checkOutput("lit.lk.l1",  32'(en_l1),    32'hF);
        checkOutput("lit.lk.cnt", 32'(wake_cnt), 32'h6);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
        checkOutput("lit.lk.act", 32'(bank_active), 32'hF);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
        checkOutput("lit.lk.slp", 32'(bank_active), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 1, 0, 0, 4'b0000, 1, 0, 0);
        checkOutput("lit.lk2.cnt", 32'(wake_cnt),   32'hA);
        checkOutput("lit.lk2.sat", 32'(s_wake_cnt), 32'h7);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 1, 0, 0);

        // TestM3 masks the array enable of an active write to bank 0.
        applyStimulus(1, 1, 1, 0, 0, 1, 4'b0001, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 1, 4'b0001, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 1, 4'b0001, 0, 1, 0);
        checkOutput("lit.m3.pre", 32'(en_pre), 32'h1);
        checkOutput("lit.m3.l1",  32'(en_l1),  32'h0);
        applyStimulus(1, 1, 1, 0, 0, 1, 4'b0001, 0, 0, 0);
        checkOutput("lit.m3.after", 32'(en_l1), 32'h1);

        // Reset asserted while bank 0 is in HOLD.
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        checkOutput("lit.rsthold.act", 32'(bank_active), 32'h1);
        checkOutput("lit.rsthold.cnt", 32'(wake_cnt),    32'hB);
        applyStimulus(0, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0);
        checkOutput("lit.rstdone.act", 32'(bank_active), 32'h0);
        checkOutput("lit.rstdone.cnt", 32'(wake_cnt),    32'h0);

        // Randomized traffic with occasional resets and test overrides.
        for (int i = 0; i < RAND_N; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          NB'($urandom),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 5) == 0));
        end

        @(posedge CB);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
